// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
//   state_t  : responder FSM states (idle, counting wait cycles, holding a response)
//   WaitCycW : width of the wait counter and of the WAIT_CYC parameter range (0..15)
package imem_pkg;

  localparam int unsigned WaitCycW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side handshake bundle between the instruction fetch unit and the responder.
//   req_valid/req_ready/req_addr             : fetch request (byte address)
//   resp_valid/resp_ready                    : response handshake
//   resp_data/resp_addr/resp_err             : instruction word, answered address, fault flag
//   flush                                    : PC redirect, drops whatever is in flight
// master = fetch unit, slave = responder.
interface imem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [31:0] resp_addr;
  logic        resp_err;
  logic        flush;

  modport master (
    output req_valid, req_addr, resp_ready, flush,
    input  req_ready, resp_valid, resp_data, resp_addr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, flush,
    output req_ready, resp_valid, resp_data, resp_addr, resp_err
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port (program load) and one
// combinational read port. Contents are not reset.
//   clk    : write clock
//   we     : write enable
//   waddr  : write word index
//   wdata  : write data
//   raddr  : read word index
//   rdata  : read data (current contents, so a same-edge write is not yet visible)
module imem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, waits WAIT_CYC cycles, then
// holds the instruction word until the fetch side takes it. A flush drops anything in flight.
//   clk, reset                   : clock, asynchronous active-high reset
//   bus (slave)                  : fetch request/response handshake plus flush
//   prog_we/prog_addr/prog_data  : word-write load port for preloading programs
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  imem_responder_if.slave          bus,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Byte span of the array; one extra bit so DEPTH*4 cannot wrap.
  localparam logic [32:0] Limit = 33'(DEPTH) << 2;
  localparam logic [WaitCycW-1:0] CntLoad =
      (WAIT_CYC == 0) ? '0 : WaitCycW'(WAIT_CYC - 1);

  state_t              state;
  logic [WaitCycW-1:0] cnt;
  logic [31:0]         addr_q;
  logic                resp_valid_q;
  logic [31:0]         resp_data_q;
  logic [31:0]         resp_addr_q;
  logic                resp_err_q;

  logic                accept;
  logic                enter_resp;
  logic [31:0]         eval_addr;
  logic [31:0]         off;
  logic                eval_err;
  logic [31:0]         rd_data;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (off[AW+1:2]),
    .rdata (rd_data)
  );

  always_comb begin
    bus.req_ready = 1'b0;
    unique case (state)
      StIdle:  bus.req_ready = !bus.flush;
      StResp:  bus.req_ready = bus.resp_ready && !bus.flush;
      default: bus.req_ready = 1'b0;
    endcase
  end

  // RESP is entered either from WAIT (address already latched) or straight from an
  // accept when WAIT_CYC is 0 (address still on the request bus).
  always_comb begin
    eval_addr  = (state == StWait) ? addr_q : bus.req_addr;
    off        = eval_addr - BASE;
    eval_err   = (eval_addr[1:0] != 2'b00) || ({1'b0, off} >= Limit);
    accept     = bus.req_valid && bus.req_ready;
    enter_resp = !bus.flush &&
                 ((accept && (WAIT_CYC == 0)) || ((state == StWait) && (cnt == '0)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      cnt          <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_addr_q  <= '0;
      resp_err_q   <= 1'b0;
    end else if (bus.flush) begin
      // Flush wins over the response handshake and any accept.
      state        <= StIdle;
      resp_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= bus.req_addr;
      end
      if (enter_resp) begin
        state        <= StResp;
        resp_valid_q <= 1'b1;
        resp_data_q  <= eval_err ? 32'h0 : rd_data;
        resp_addr_q  <= eval_addr;
        resp_err_q   <= eval_err;
      end else if (accept) begin
        state        <= StWait;
        cnt          <= CntLoad;
        resp_valid_q <= 1'b0;
      end else if (state == StWait) begin
        cnt <= cnt - 1'b1;
      end else if ((state == StResp) && bus.resp_ready) begin
        state        <= StIdle;
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_addr  = resp_addr_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: dut_a runs with WAIT_CYC=2, dut_b with WAIT_CYC=0.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we_a;
  logic        prog_we_b;
  logic [9:0]  prog_addr;
  logic [31:0] prog_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] prog_words [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

  imem_responder_if ifa ();
  imem_responder_if ifb ();

  always #5 clk = ~clk;

  imem_responder #(
    .BASE     (32'h0000_0000),
    .DEPTH    (1024),
    .WAIT_CYC (2)
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifa),
    .prog_we   (prog_we_a),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  imem_responder #(
    .BASE     (32'h0000_0000),
    .DEPTH    (1024),
    .WAIT_CYC (0)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifb),
    .prog_we   (prog_we_b),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one request to dut_a, then wait (bounded) for its response and check it.
  task automatic fetch_a(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err);
    int lat;
    ifa.req_valid = 1'b1;
    ifa.req_addr  = addr;
    #1;
    check_eq("a_req_ready", 32'(ifa.req_ready), 1);
    step();
    ifa.req_valid = 1'b0;
    lat = 1;
    while (!ifa.resp_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq("a_latency", 32'(lat), 3);
    check_eq("a_resp_valid", 32'(ifa.resp_valid), 1);
    check_eq("a_resp_data", ifa.resp_data, exp_data);
    check_eq("a_resp_addr", ifa.resp_addr, addr);
    check_eq("a_resp_err", 32'(ifa.resp_err), 32'(exp_err));
  endtask

  initial begin
    int seen;
    reset          = 1'b1;
    prog_we_a      = 1'b0;
    prog_we_b      = 1'b0;
    prog_addr      = '0;
    prog_data      = '0;
    ifa.req_valid  = 1'b0;
    ifa.req_addr   = '0;
    ifa.resp_ready = 1'b0;
    ifa.flush      = 1'b0;
    ifb.req_valid  = 1'b0;
    ifb.req_addr   = '0;
    ifb.resp_ready = 1'b0;
    ifb.flush      = 1'b0;
    repeat (2) step();

    // Reset values
    check_eq("rst_a_valid", 32'(ifa.resp_valid), 0);
    check_eq("rst_a_data", ifa.resp_data, 0);
    check_eq("rst_a_addr", ifa.resp_addr, 0);
    check_eq("rst_a_err", 32'(ifa.resp_err), 0);
    check_eq("rst_b_valid", 32'(ifb.resp_valid), 0);
    reset = 1'b0;
    #1;
    check_eq("rst_a_req_ready", 32'(ifa.req_ready), 1);
    check_eq("rst_b_req_ready", 32'(ifb.req_ready), 1);
    step();

    // Preload both arrays
    for (int i = 0; i < 4; i++) begin
      prog_we_a = 1'b1;
      prog_we_b = 1'b1;
      prog_addr = 10'(i);
      prog_data = prog_words[i];
      step();
    end
    prog_we_a = 1'b0;
    prog_we_b = 1'b0;
    ifa.resp_ready = 1'b1;
    ifb.resp_ready = 1'b1;

    // Basic fetches, WAIT_CYC=2
    fetch_a(32'h0, 32'h0000_0013, 1'b0);
    fetch_a(32'h4, 32'h0010_0093, 1'b0);
    step();
    check_eq("a_hs_idle", 32'(ifa.resp_valid), 0);

    // Backpressure: response held for 5 cycles
    ifa.resp_ready = 1'b0;
    fetch_a(32'h8, 32'h0020_0113, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_eq("a_bp_valid", 32'(ifa.resp_valid), 1);
      check_eq("a_bp_data", ifa.resp_data, 32'h0020_0113);
      check_eq("a_bp_req_ready", 32'(ifa.req_ready), 0);
      step();
    end
    ifa.resp_ready = 1'b1;
    step();
    check_eq("a_bp_single_hs", 32'(ifa.resp_valid), 0);

    // Error cases
    fetch_a(32'h6, 32'h0, 1'b1);
    step();
    fetch_a(32'h0000_1000, 32'h0, 1'b1);
    step();
    fetch_a(32'hFFFF_FFFC, 32'h0, 1'b1);
    step();

    // Flush during WAIT
    ifa.req_valid = 1'b1;
    ifa.req_addr  = 32'hC;
    step();
    ifa.req_valid = 1'b0;
    ifa.flush     = 1'b1;
    #1;
    check_eq("a_flush_wait_ready", 32'(ifa.req_ready), 0);
    step();
    ifa.flush = 1'b0;
    #1;
    check_eq("a_flush_wait_ready_after", 32'(ifa.req_ready), 1);
    seen = 0;
    repeat (6) begin
      if (ifa.resp_valid) seen++;
      step();
    end
    check_eq("a_flush_wait_no_resp", 32'(seen), 0);

    // Flush in RESP with resp_ready high and a new request offered
    fetch_a(32'hC, 32'h0030_0193, 1'b0);
    ifa.flush     = 1'b1;
    ifa.req_valid = 1'b1;
    ifa.req_addr  = 32'h0;
    #1;
    check_eq("a_flush_resp_ready", 32'(ifa.req_ready), 0);
    step();
    ifa.flush     = 1'b0;
    ifa.req_valid = 1'b0;
    check_eq("a_flush_resp_drop", 32'(ifa.resp_valid), 0);
    seen = 0;
    repeat (6) begin
      if (ifa.resp_valid) seen++;
      step();
    end
    check_eq("a_flush_req_ignored", 32'(seen), 0);

    // Load port: write then fetch
    prog_we_a = 1'b1;
    prog_addr = 10'd1;
    prog_data = 32'hDEAD_BEEF;
    step();
    prog_we_a = 1'b0;
    fetch_a(32'h4, 32'hDEAD_BEEF, 1'b0);
    step();

    // Write on the RESP-entry edge returns the old word
    ifa.req_valid = 1'b1;
    ifa.req_addr  = 32'h4;
    step();
    ifa.req_valid = 1'b0;
    step();
    prog_we_a = 1'b1;
    prog_addr = 10'd1;
    prog_data = 32'h1111_1111;
    step();
    prog_we_a = 1'b0;
    check_eq("a_same_edge_valid", 32'(ifa.resp_valid), 1);
    check_eq("a_same_edge_old", ifa.resp_data, 32'hDEAD_BEEF);
    step();
    fetch_a(32'h4, 32'h1111_1111, 1'b0);
    step();

    // WAIT_CYC=0 back-to-back stream
    ifb.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifb.req_addr = 32'(i * 4);
      step();
      check_eq("b_stream_valid", 32'(ifb.resp_valid), 1);
      check_eq("b_stream_data", ifb.resp_data, prog_words[i]);
      check_eq("b_stream_addr", ifb.resp_addr, 32'(i * 4));
    end
    ifb.req_addr = 32'h0;
    step();

    // Reset mid-stream
    reset = 1'b1;
    #1;
    check_eq("b_rst_valid", 32'(ifb.resp_valid), 0);
    check_eq("b_rst_data", ifb.resp_data, 0);
    check_eq("b_rst_addr", ifb.resp_addr, 0);
    check_eq("b_rst_err", 32'(ifb.resp_err), 0);
    check_eq("b_rst_req_ready", 32'(ifb.req_ready), 1);
    ifb.req_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check_eq("b_post_rst_ready", 32'(ifb.req_ready), 1);
    step();
    check_eq("b_post_rst_valid", 32'(ifb.resp_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
